// File: rtl/stage_wb_reg_multi.sv
// Parametrised pipeline stage register carrying NUM_CH write-back channels.
// It adds a valid bit, exception flush, per-lane zeroing of non-writing
// lanes, and saturating bubble/hold performance counters.

// One write-back lane: registered we/wd/wdata with bubble and zeroing control.
module stage_wb_lane #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_DIS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              kill,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_wd,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_wd,
    output logic [DATA_W-1:0] out_wdata
);
    // A killed slot is always fully zero; a live lane that does not write is
    // zeroed only when ZERO_DIS is set, so stale values never leak downstream.
    logic zero;
    assign zero = kill || ((ZERO_DIS != 0) && !in_we);

    // Lane register: cleared on reset, reloaded whenever the stage is not holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_we    <= 1'b0;
            out_wd    <= '0;
            out_wdata <= '0;
        end else if (load) begin
            out_we    <= in_we && !kill;
            out_wd    <= zero ? '0 : in_wd;
            out_wdata <= zero ? '0 : in_wdata;
        end
    end
endmodule

module stage_wb_reg_multi #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_CH   = 4,
    parameter int STALL_W  = 6,
    parameter int STAGE    = 4,
    parameter int ZERO_DIS = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic                     clr_cnt,
    input  logic                     in_valid,
    input  logic [NUM_CH-1:0]        in_we,
    input  logic [NUM_CH*ADDR_W-1:0] in_wd,
    input  logic [NUM_CH*DATA_W-1:0] in_wdata,
    output logic                     out_valid,
    output logic [NUM_CH-1:0]        out_we,
    output logic [NUM_CH*ADDR_W-1:0] out_wd,
    output logic [NUM_CH*DATA_W-1:0] out_wdata,
    output logic [CNT_W-1:0]         bubble_cnt,
    output logic [CNT_W-1:0]         hold_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic stop_cur, stop_nxt;
    logic is_bubble, is_hold;
    logic load, kill;
    logic unused_stall;

    assign stop_cur     = stall[STAGE];
    assign stop_nxt     = stall[STAGE+1];
    assign unused_stall = ^stall;

    // Flush beats every stall combination, so it suppresses both counters.
    assign is_bubble = !flush && stop_cur && !stop_nxt;
    assign is_hold   = !flush && stop_cur && stop_nxt;

    // Register loads on flush, bubble or pass; only a true hold freezes it.
    assign load = !is_hold;
    // Anything other than a live pass of a valid instruction becomes a bubble.
    assign kill = flush || stop_cur || !in_valid;

    // Valid bit follows the same load/kill decode as the lanes.
    always_ff @(posedge clk) begin
        if (rst)       out_valid <= 1'b0;
        else if (load) out_valid <= in_valid && !kill;
    end

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_lane
            stage_wb_lane #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .ZERO_DIS(ZERO_DIS)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .load     (load),
                .kill     (kill),
                .in_we    (in_we[k]),
                .in_wd    (in_wd[k*ADDR_W +: ADDR_W]),
                .in_wdata (in_wdata[k*DATA_W +: DATA_W]),
                .out_we   (out_we[k]),
                .out_wd   (out_wd[k*ADDR_W +: ADDR_W]),
                .out_wdata(out_wdata[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Bubble counter: counts stall-inserted bubbles only, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt)                       bubble_cnt <= '0;
        else if (is_bubble && bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
    end

    // Hold counter: counts cycles the register kept its contents, saturating.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt)                     hold_cnt <= '0;
        else if (is_hold && hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + 1'b1;
    end
endmodule

// File: tb/tb_stage_wb_reg_multi.sv
// Self-checking bench for stage_wb_reg_multi: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_stage_wb_reg_multi;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NUM_CH  = 4;
    localparam int STALL_W = 6;
    localparam int STAGE   = 4;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [STALL_W-1:0]       stall;
    logic                     flush, clr_cnt, in_valid;
    logic [NUM_CH-1:0]        in_we;
    logic [NUM_CH*ADDR_W-1:0] in_wd;
    logic [NUM_CH*DATA_W-1:0] in_wdata;
    logic                     out_valid;
    logic [NUM_CH-1:0]        out_we;
    logic [NUM_CH*ADDR_W-1:0] out_wd;
    logic [NUM_CH*DATA_W-1:0] out_wdata;
    logic [CNT_W-1:0]         bubble_cnt, hold_cnt;

    stage_wb_reg_multi #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .STALL_W(STALL_W),
        .STAGE(STAGE), .ZERO_DIS(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_we(in_we), .in_wd(in_wd), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_we(out_we), .out_wd(out_wd), .out_wdata(out_wdata),
        .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state, kept per channel as plain arrays.
    logic              m_valid;
    logic              m_we    [NUM_CH];
    logic [ADDR_W-1:0] m_wd    [NUM_CH];
    logic [DATA_W-1:0] m_wdata [NUM_CH];
    int                m_bc, m_hc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the stage rules, in priority order, to the inputs seen at this edge.
    task automatic model_update();
        bit cur, nxt, to_bubble;
        cur = stall[STAGE];
        nxt = stall[STAGE+1];
        if (rst) begin
            m_valid = 0; m_bc = 0; m_hc = 0;
            for (int k = 0; k < NUM_CH; k++) begin m_we[k] = 0; m_wd[k] = 0; m_wdata[k] = 0; end
            return;
        end
        if (clr_cnt) begin
            m_bc = 0; m_hc = 0;
        end else if (!flush && cur && !nxt) begin
            m_bc = (m_bc + 1 > CMAX) ? CMAX : m_bc + 1;
        end else if (!flush && cur && nxt) begin
            m_hc = (m_hc + 1 > CMAX) ? CMAX : m_hc + 1;
        end
        to_bubble = flush || (cur && !nxt) || (!cur && !in_valid);
        if (to_bubble) begin
            m_valid = 0;
            for (int k = 0; k < NUM_CH; k++) begin m_we[k] = 0; m_wd[k] = 0; m_wdata[k] = 0; end
        end else if (!cur) begin
            m_valid = 1;
            for (int k = 0; k < NUM_CH; k++) begin
                m_we[k]    = in_we[k];
                m_wd[k]    = in_we[k] ? in_wd[k*ADDR_W +: ADDR_W] : '0;
                m_wdata[k] = in_we[k] ? in_wdata[k*DATA_W +: DATA_W] : '0;
            end
        end
    endtask

    task automatic chk_model(input string tag);
        logic [NUM_CH-1:0]        e_we;
        logic [NUM_CH*ADDR_W-1:0] e_wd;
        logic [NUM_CH*DATA_W-1:0] e_wdata;
        for (int k = 0; k < NUM_CH; k++) begin
            e_we[k]                    = m_we[k];
            e_wd[k*ADDR_W +: ADDR_W]    = m_wd[k];
            e_wdata[k*DATA_W +: DATA_W] = m_wdata[k];
        end
        chk({tag, ".valid"},  128'(out_valid),  128'(m_valid));
        chk({tag, ".we"},     128'(out_we),     128'(e_we));
        chk({tag, ".wd"},     128'(out_wd),     128'(e_wd));
        chk({tag, ".wdata"},  128'(out_wdata),  128'(e_wdata));
        chk({tag, ".bubble"}, 128'(bubble_cnt), 128'(m_bc));
        chk({tag, ".hold"},   128'(hold_cnt),   128'(m_hc));
    endtask

    // One clock: update model at the edge, sample DUT 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        chk_model(tag);
    endtask

    task automatic rand_inputs();
        in_we    = NUM_CH'($urandom);
        in_wd    = (NUM_CH*ADDR_W)'({$urandom, $urandom});
        in_wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        // T1: reset with nonzero inputs
        rst = 1; stall = '0; flush = 0; clr_cnt = 0; in_valid = 1;
        in_we = '1; in_wd = '1; in_wdata = '1;
        step("t1a");
        step("t1b");
        chk("t1.valid", 128'(out_valid), 128'(0));
        chk("t1.wdata", 128'(out_wdata), 128'(0));
        chk("t1.bubble", 128'(bubble_cnt), 128'(0));
        chk("t1.hold", 128'(hold_cnt), 128'(0));

        // T2: pass with one writing and one non-writing lane
        rst = 0; stall = '0; in_valid = 1;
        rand_inputs();
        in_we[0] = 1; in_wd[4:0] = 5'd3;  in_wdata[31:0]  = 32'hDEADBEEF;
        in_we[1] = 0; in_wd[9:5] = 5'd7;  in_wdata[63:32] = 32'h1234;
        step("t2");
        chk("t2.valid", 128'(out_valid), 128'(1));
        chk("t2.wd0", 128'(out_wd[4:0]), 128'(3));
        chk("t2.wdata0", 128'(out_wdata[31:0]), 128'(32'hDEADBEEF));
        chk("t2.we1", 128'(out_we[1]), 128'(0));
        chk("t2.wd1", 128'(out_wd[9:5]), 128'(0));
        chk("t2.wdata1", 128'(out_wdata[63:32]), 128'(0));

        // T3: bubble then hold
        stall = 6'b010000;
        step("t3b");
        chk("t3.bubble", 128'(bubble_cnt), 128'(1));
        chk("t3.bvalid", 128'(out_valid), 128'(0));
        stall = 6'b110000;
        for (int i = 0; i < 3; i++) begin rand_inputs(); step("t3h"); end
        chk("t3.hold", 128'(hold_cnt), 128'(3));
        chk("t3.bubble2", 128'(bubble_cnt), 128'(1));

        // T4: flush overrides hold
        stall = '0; in_valid = 1; in_we = '1; rand_inputs(); in_we = '1;
        step("t4p");
        flush = 1; stall = 6'b110000; rand_inputs();
        step("t4f");
        chk("t4.valid", 128'(out_valid), 128'(0));
        chk("t4.we", 128'(out_we), 128'(0));
        chk("t4.hold", 128'(hold_cnt), 128'(3));
        flush = 0;

        // T5: saturation, then clear coinciding with a bubble
        stall = 6'b010000;
        for (int i = 0; i < 20; i++) step("t5s");
        chk("t5.sat", 128'(bubble_cnt), 128'(15));
        clr_cnt = 1;
        step("t5c");
        chk("t5.clr", 128'(bubble_cnt), 128'(0));
        clr_cnt = 0;

        // T6: reset in the middle of a hold, then a fresh pass
        stall = '0; in_valid = 1; rand_inputs(); in_we = '1;
        step("t6p");
        stall = 6'b110000;
        step("t6h");
        rst = 1;
        step("t6r");
        chk("t6.valid", 128'(out_valid), 128'(0));
        chk("t6.wdata", 128'(out_wdata), 128'(0));
        rst = 0; stall = '0; in_valid = 1; in_we = 4'b1010;
        in_wdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        step("t6n");
        chk("t6.new", 128'(out_wdata), {32'h44444444, 32'h0, 32'h22222222, 32'h0});

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            clr_cnt  = ($urandom_range(0, 29) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = STALL_W'($urandom);
            rand_inputs();
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
